// File: rtl/rf_read_arbiter_if.sv
// Bundle of requester, writeback and register-file port signals around the read arbiter.
// Latency: none, wiring only.
// Backpressure: grant-based; a requester holds its request until it sees its grant.
interface rf_read_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              rd0_req;
    logic [ADDR_W-1:0] rd0_addr;
    logic              rd0_gnt;
    logic              rd0_rvalid;
    logic [DATA_W-1:0] rd0_rdata;

    logic              rd1_req;
    logic [ADDR_W-1:0] rd1_addr;
    logic              rd1_gnt;
    logic              rd1_rvalid;
    logic [DATA_W-1:0] rd1_rdata;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic [ADDR_W-1:0] rf_rd_addr;
    logic [DATA_W-1:0] rf_rd_data;
    logic [ADDR_W-1:0] rf_wr_addr;
    logic [DATA_W-1:0] rf_wr_data;
    logic              rf_we;

    // Arbiter side
    modport slave (
        input  rd0_req, rd0_addr, rd1_req, rd1_addr,
        input  wr_en, wr_addr, wr_data, rf_rd_data,
        output rd0_gnt, rd0_rvalid, rd0_rdata,
        output rd1_gnt, rd1_rvalid, rd1_rdata,
        output rf_rd_addr, rf_wr_addr, rf_wr_data, rf_we
    );

    // Requesters, writeback and register file side
    modport master (
        output rd0_req, rd0_addr, rd1_req, rd1_addr,
        output wr_en, wr_addr, wr_data, rf_rd_data,
        input  rd0_gnt, rd0_rvalid, rd0_rdata,
        input  rd1_gnt, rd1_rvalid, rd1_rdata,
        input  rf_rd_addr, rf_wr_addr, rf_wr_data, rf_we
    );
endinterface

// File: rtl/rf_read_arbiter.sv
// Shares the register file read port between decode (0) and debug (1), with write-to-read bypass.
// Latency: grant same cycle as request, rvalid/rdata exactly one cycle after the grant.
// Backpressure: a losing requester holds req/addr until granted; writes are never stalled.
module rf_read_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RR_EN  = 1
) (
    input logic clk,
    input logic rst_n,
    rf_read_arbiter_if.slave bus
);
    logic              prio_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              rsp_vld_q;
    logic              rsp_id_q;
    logic              byp_vld_q;
    logic [DATA_W-1:0] byp_data_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    logic              any_gnt;
    logic              gnt_id;
    logic [ADDR_W-1:0] gnt_addr;
    logic              byp_hit;
    logic [DATA_W-1:0] rsp_data;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;

    // Pick the winner; gnt_id is only meaningful when any_gnt is set
    always_comb begin
        any_gnt = rst_n & (bus.rd0_req | bus.rd1_req);
        if (bus.rd0_req && bus.rd1_req) begin
            gnt_id = (RR_EN != 0) ? prio_q : 1'b0;
        end else begin
            gnt_id = ~bus.rd0_req;
        end
        gnt_addr = gnt_id ? bus.rd1_addr : bus.rd0_addr;
        // Full-width compare so aliased high address bits never bypass
        byp_hit  = any_gnt & bus.wr_en & (bus.wr_addr == gnt_addr);
    end

    // Response data: bypass beats the register file, which is stale on a same-cycle write
    always_comb begin
        rsp_data = byp_vld_q ? byp_data_q : bus.rf_rd_data;
        rvalid0  = rsp_vld_q & ~rsp_id_q;
        rvalid1  = rsp_vld_q & rsp_id_q;
        rdata0   = rvalid0 ? rsp_data : rdata0_q;
        rdata1   = rvalid1 ? rsp_data : rdata1_q;
    end

    assign bus.rd0_gnt    = any_gnt & ~gnt_id;
    assign bus.rd1_gnt    = any_gnt & gnt_id;
    assign bus.rf_rd_addr = any_gnt ? gnt_addr : rd_addr_q;
    assign bus.rf_wr_addr = bus.wr_addr;
    assign bus.rf_wr_data = bus.wr_data;
    assign bus.rf_we      = bus.wr_en;
    assign bus.rd0_rvalid = rvalid0;
    assign bus.rd1_rvalid = rvalid1;
    assign bus.rd0_rdata  = rdata0;
    assign bus.rd1_rdata  = rdata1;

    // Round-robin pointer and the held read address for idle cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q    <= 1'b0;
            rd_addr_q <= '0;
        end else if (any_gnt) begin
            rd_addr_q <= gnt_addr;
            if (RR_EN != 0) begin
                prio_q <= ~gnt_id;
            end
        end
    end

    // Response stage: remember who was granted and whether a write must be forwarded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_vld_q  <= 1'b0;
            rsp_id_q   <= 1'b0;
            byp_vld_q  <= 1'b0;
            byp_data_q <= '0;
        end else begin
            rsp_vld_q <= any_gnt;
            rsp_id_q  <= gnt_id;
            byp_vld_q <= byp_hit;
            if (byp_hit) begin
                byp_data_q <= bus.wr_data;
            end
        end
    end

    // Each requester's rdata holds its last delivered value between responses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            rdata0_q <= rdata0;
            rdata1_q <= rdata1;
        end
    end
endmodule

// File: doc/rf_read_arbiter.md
Name: rf_read_arbiter

Overview:
- Shares the register file's single synchronous read port between two read requesters: requester 0 (decode) and requester 1 (debug/trace).
- Passes the single write port straight through.
- Adds write-to-read bypass, because the register file returns stale data when the same address is written in the read cycle.
- Sits between the requesters and the register file; owns rf read address, write address, write data and write enable.

Parameters:
- ADDR_W, 32, register address width.
- DATA_W, 32, register data width.
- RR_EN, 1: 1 = round-robin arbitration; 0 = fixed priority, requester 0 wins.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- rd0_req  in  1  requester 0 read request; held until granted.
- rd0_addr  in  ADDR_W  requester 0 read address; stable while rd0_req is high.
- rd0_gnt  out  1  requester 0 granted this cycle (combinational).
- rd0_rvalid  out  1  requester 0 read data valid (registered).
- rd0_rdata  out  DATA_W  requester 0 read data.
- rd1_req, rd1_addr, rd1_gnt, rd1_rvalid, rd1_rdata: same as requester 0, for requester 1.
- wr_en  in  1  write request from writeback; always accepted.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- rf_rd_addr  out  ADDR_W  to register file read address.
- rf_rd_data  in  DATA_W  from register file; valid 1 cycle after rf_rd_addr is sampled.
- rf_wr_addr, rf_wr_data, rf_we  out  to register file write port; combinational copies of wr_addr, wr_data, wr_en.

Behaviour:
- State:
  - prio pointer (1 bit).
  - response stage: rsp_vld, rsp_id, byp_vld, byp_data.
- Async reset values:
  - prio=0; rsp_vld=0; rsp_id=0; byp_vld=0; byp_data=0.
  - All rvalid outputs 0; all rdata outputs 0.
  - Gnt outputs are 0 while rst_n is low.
- Grant (combinational, same cycle as req):
  - Only one requester: it is granted.
  - Both requesting, RR_EN=1: grant requester prio.
  - Both requesting, RR_EN=0: grant requester 0.
  - At most one gnt is high per cycle.
- rf_rd_addr = address of the granted requester.
  - No grant: rf_rd_addr holds its last granted value (registered copy); no read is launched.
- Pointer update (RR_EN=1): on any grant, prio <= ~granted_id. No grant leaves prio unchanged.
- Handshake:
  - A requester sees gnt in the cycle its request is accepted.
  - It may drop req or present a new address the following cycle.
  - An ungranted requester must hold req and addr stable.
- Latency:
  - Grant in cycle N gives rdX_rvalid=1 for exactly cycle N+1, with rdata in that cycle.
  - Back-to-back grants give back-to-back responses; throughput is 1 read/cycle total.
- Bypass:
  - If wr_en=1 and wr_addr equals the granted read address in the grant cycle N, then byp_vld<=1 and byp_data<=wr_data.
  - In cycle N+1, rdata = byp_data when byp_vld is set, else rf_rd_data.
  - A write in cycle N+1 to the same address does not affect the N+1 response.
- rdata of the non-responding requester holds its previous value.
- Writes never stall and never affect grant decisions.
- Reset mid-operation:
  - An in-flight response is dropped; no rvalid is issued after reset release.
  - prio returns to 0.
- Address compare is over the full ADDR_W bits; no truncation.

Test Plan:
- Reset: drive rst_n=0 with rd0_req=1, then release -> gnt low during reset; rd0_rvalid=0, rd0_rdata=0; first grant goes to requester 0.
- Single requester: preload reg[5]=0xDEADBEEF, rd1_req=1 with addr 5 for one cycle -> rd1_gnt=1 in cycle N; rd1_rvalid=1 and rd1_rdata=0xDEADBEEF in N+1; rd0_rvalid=0.
- Contention, RR_EN=1: both req held 4 cycles, addrs 1 and 2 -> grants alternate 0,1,0,1; responses carry reg[1],reg[2],reg[1],reg[2]; losers hold req until granted.
- Contention, RR_EN=0: both req held 3 cycles -> rd0_gnt=1 every cycle; rd1_gnt=0 every cycle.
- Bypass: reg[7]=0x11; in the grant cycle, rd0 reads 7 while wr_en=1 writes 7=0x22 -> rd0_rdata=0x22; a subsequent read of 7 returns 0x22 from the register file.
- Reset mid-flight: grant in cycle N, assert rst_n=0 before edge N+1 -> no rvalid at any time; prio=0 after release.
